ice40_serdes_align: RTL and testbench
=====================================

ICE40_SERDES_ALIGN -- requirements
Module: ice40_serdes_align

Interface
REQ-001 SHALL have parameter SYNC_PATTERN, default 8'hBC, the 8-bit frame marker searched for.
REQ-002 SHALL have parameter FRAME_LEN, default 16, the words per frame with the marker at position 0 (range 2..256).
REQ-003 SHALL have parameter LOCK_CNT, default 3, the consecutive good markers needed to lock (range 1..15).
REQ-004 SHALL have parameter UNLOCK_CNT, default 4, the consecutive missed markers that drop lock (range 1..15).
REQ-005 SHALL use a single clock and an asynchronous active-low reset: clk_1x input 1, the word clock from the SERDES CRG; rst_n input 1, the asynchronous active-low reset.
REQ-006 SHALL have port in_data, input, 8 bits: raw deserialized bits, bit 0 oldest in time.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data qualifier.
REQ-008 SHALL have port out_data, output, 8 bits: word-aligned data.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data qualifier, asserted only while LOCKED.
REQ-010 SHALL have port out_sync, output, 1 bit: asserted with out_valid on frame position 0.
REQ-011 SHALL have port locked, output, 1 bit: state == LOCKED.
REQ-012 SHALL have port bit_offset, output, 3 bits: currently applied bit offset.

Function
REQ-013 SHALL hold prev[7:0], loaded with in_data on each in_valid; window w = {in_data, prev}; candidate k = w[k+7:k], k = 0..7.
REQ-014 SHALL implement a three-state FSM: HUNT, VERIFY, LOCKED; all transitions occur only on in_valid cycles.
REQ-015 HUNT: if any candidate equals SYNC_PATTERN, SHALL latch the lowest matching k into bit_offset, set frame position to 0 and good count to 1, and go to VERIFY (or straight to LOCKED if LOCK_CNT == 1).
REQ-016 SHALL advance the frame position by 1 per in_valid, wrapping FRAME_LEN-1 -> 0.
REQ-017 VERIFY: at position 0, candidate[bit_offset] == SYNC_PATTERN SHALL increment the good count and enter LOCKED on reaching LOCK_CNT; a mismatch SHALL return to HUNT, with the same cycle not re-searched.
REQ-018 LOCKED: a mismatch at position 0 SHALL increment the miss count and enter HUNT on reaching UNLOCK_CNT; a match SHALL clear the miss count.
REQ-019 out_data, out_valid and out_sync SHALL be registered with 1-cycle latency from the in_valid cycle, out_data = candidate[bit_offset].
REQ-020 out_valid SHALL be 1 only if the state was LOCKED in the input cycle, including the cycle of the final miss.
REQ-021 Cycles with in_valid = 0 SHALL hold all state, force out_valid = 0, and cause no output holes beyond the missing input.
REQ-022 bit_offset SHALL change only on the HUNT -> VERIFY/LOCKED transition.

Reset
REQ-023 On rst_n low, asynchronously: state HUNT; prev, position, counts and bit_offset 0; out_data 0; out_valid, out_sync and locked 0.
REQ-024 Reset asserted mid-frame SHALL abandon lock immediately; after release the block behaves as from power-up.

Configuration
REQ-025 With macro ICE40_SERDES_ALIGN_STATS_EN defined, the block SHALL add output err_cnt[15:0]: it increments on each LOCKED marker miss, saturates at 16'hFFFF, and clears only on reset.
REQ-026 Without ICE40_SERDES_ALIGN_STATS_EN, the err_cnt port and its logic SHALL be absent, with no other behaviour change.

Structure
REQ-027 FSM state encodings (HUNT = 0, VERIFY = 1, LOCKED = 2) SHALL live in the shared ice40_serdes package/header.
REQ-028 Candidate extraction SHALL be one sub-module, ice40_serdes_align_shift: window[15:0] plus offset[2:0] in, word[7:0] out, purely combinational; it is instantiated once for output and once per k or as a compare array.

Verification
REQ-029 Stream with marker 8'hBC at offset 3, every 16 words, in_valid = 1 -> bit_offset = 3; locked rises after the 3rd marker; out_sync on each marker; out_data = 8'hBC at out_sync.
REQ-030 Locked, then 3 corrupted markers followed by 1 good marker -> locked stays 1, miss count clears; with STATS_EN, err_cnt = 3.
REQ-031 Locked, then 4 consecutive corrupted markers -> locked = 0 on the 4th; out_valid goes 0 from the following input.
REQ-032 2nd marker corrupted during VERIFY -> returns to HUNT; relocks after 3 further good markers.
REQ-033 in_valid toggled 1/0 randomly on a locked stream -> out_data sequence equals the aligned input sequence with no loss or duplication.
REQ-034 rst_n pulsed low mid-frame while LOCKED -> all outputs 0 asynchronously; after release, reacquires as in REQ-029.

Source files
------------

// File: rtl/ice40_serdes_pkg.sv
// Shared definitions for the iCE40 SERDES word aligner: FSM encodings and the
// lowest-offset priority pick used while hunting for the frame marker.
package ice40_serdes_pkg;

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  function automatic logic [2:0] lowest_hit(input logic [7:0] hits);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (hits[k]) idx = 3'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ice40_serdes_align_shift.sv
// Picks one 8-bit candidate word out of the 16-bit two-word window.
// Window bit 0 is the oldest bit, so offset k selects window[k+7:k].
module ice40_serdes_align_shift (
  input  logic [15:0] window,
  input  logic [2:0]  offset,
  output logic [7:0]  word
);

  assign word = window[offset +: 8];

endmodule

// File: rtl/ice40_serdes_align.sv
// Frame-marker word aligner: hunts for SYNC_PATTERN at any bit offset, verifies
// it over LOCK_CNT frames, then emits aligned words. Define
// ICE40_SERDES_ALIGN_STATS_EN to add the saturating err_cnt output.
module ice40_serdes_align
  import ice40_serdes_pkg::*;
#(
  parameter logic [7:0] SYNC_PATTERN = 8'hBC,
  parameter int         FRAME_LEN    = 16,
  parameter int         LOCK_CNT     = 3,
  parameter int         UNLOCK_CNT   = 4
) (
  input  logic        clk_1x,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sync,
  output logic        locked,
  output logic [2:0]  bit_offset,
  output logic [1:0]  fsm_state
`ifdef ICE40_SERDES_ALIGN_STATS_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  logic [1:0]  state;
  logic [7:0]  prev;
  logic [7:0]  pos;
  logic [3:0]  good_cnt;
  logic [3:0]  miss_cnt;
  logic [15:0] window;
  logic [7:0]  cand [8];
  logic [7:0]  hits;
  logic [7:0]  aligned;
  logic [7:0]  pos_next;
  logic        at_marker;
  logic        marker_ok;
  logic        locked_miss;

  assign window = {in_data, prev};

  for (genvar k = 0; k < 8; k++) begin : g_cand
    ice40_serdes_align_shift u_cand (
      .window (window),
      .offset (3'(k)),
      .word   (cand[k])
    );
    assign hits[k] = (cand[k] == SYNC_PATTERN);
  end

  ice40_serdes_align_shift u_out (
    .window (window),
    .offset (bit_offset),
    .word   (aligned)
  );

  assign pos_next    = (pos == 8'(FRAME_LEN - 1)) ? 8'd0 : pos + 8'd1;
  assign at_marker   = (pos == 8'd0);
  assign marker_ok   = (aligned == SYNC_PATTERN);
  assign locked_miss = in_valid && (state == ST_LOCKED) && at_marker && !marker_ok;
  assign locked      = (state == ST_LOCKED);
  assign fsm_state   = state;

  // pos is the frame position of the word currently on the input.
  always_ff @(posedge clk_1x or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_HUNT;
      prev       <= 8'd0;
      pos        <= 8'd0;
      good_cnt   <= 4'd0;
      miss_cnt   <= 4'd0;
      bit_offset <= 3'd0;
      out_data   <= 8'd0;
      out_valid  <= 1'b0;
      out_sync   <= 1'b0;
    end else begin
      out_valid <= in_valid && (state == ST_LOCKED);
      out_sync  <= in_valid && (state == ST_LOCKED) && at_marker;
      if (in_valid) begin
        prev     <= in_data;
        out_data <= aligned;
        pos      <= pos_next;
        case (state)
          ST_HUNT: begin
            if (|hits) begin
              // The matched word is position 0, so the next word is position 1.
              bit_offset <= lowest_hit(hits);
              pos        <= 8'd1;
              good_cnt   <= 4'd1;
              miss_cnt   <= 4'd0;
              state      <= (LOCK_CNT == 1) ? ST_LOCKED : ST_VERIFY;
            end
          end
          ST_VERIFY: begin
            if (at_marker) begin
              if (marker_ok) begin
                good_cnt <= good_cnt + 4'd1;
                if (good_cnt == 4'(LOCK_CNT - 1)) begin
                  state    <= ST_LOCKED;
                  miss_cnt <= 4'd0;
                end
              end else begin
                state <= ST_HUNT;
              end
            end
          end
          ST_LOCKED: begin
            if (at_marker) begin
              if (marker_ok) begin
                miss_cnt <= 4'd0;
              end else begin
                miss_cnt <= miss_cnt + 4'd1;
                if (miss_cnt == 4'(UNLOCK_CNT - 1)) state <= ST_HUNT;
              end
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

`ifdef ICE40_SERDES_ALIGN_STATS_EN
  always_ff @(posedge clk_1x or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 16'd0;
    end else if (locked_miss && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = locked_miss;
`endif

endmodule

// File: tb/tb_ice40_serdes_align.sv
// Directed bench for ice40_serdes_align: builds an aligned word stream, shifts it
// by a chosen bit offset into raw words, and scoreboards the aligned output.
module tb_ice40_serdes_align;

  localparam logic [7:0] SYNC  = 8'hBC;
  localparam int         FRAME = 16;

  logic        clk_1x = 1'b0;
  logic        rst_n  = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_sync;
  logic        locked;
  logic [2:0]  bit_offset;
  logic [1:0]  fsm_state;
`ifdef ICE40_SERDES_ALIGN_STATS_EN
  logic [15:0] err_cnt;
`endif

  ice40_serdes_align dut (
    .clk_1x     (clk_1x),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_sync   (out_sync),
    .locked     (locked),
    .bit_offset (bit_offset),
    .fsm_state  (fsm_state)
`ifdef ICE40_SERDES_ALIGN_STATS_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  // clock / reset
  always #5 clk_1x = ~clk_1x;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         aidx;
  int         off;
  logic [7:0] a_prev;
  logic       exp_lock;
  bit         bad_marker [int];
  logic [7:0] exp_q [$];
  logic       sync_q [$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Payload masks bits 0 and 4, so no run of four ones exists outside a marker
  // and the marker can only be found at its true alignment.
  function automatic logic [7:0] gen(input int idx);
    if (idx % FRAME == 0) return bad_marker.exists(idx) ? 8'h00 : SYNC;
    return 8'(idx * 37 + 11) & 8'hEE;
  endfunction

  task automatic send(input logic valid);
    logic [7:0]  a_cur;
    logic [15:0] pair;
    if (valid) begin
      a_cur    = gen(aidx);
      pair     = {a_cur, a_prev} >> (8 - off);
      in_data  = pair[7:0];
      in_valid = 1'b1;
      if (exp_lock) begin
        exp_q.push_back(a_prev);
        sync_q.push_back(((aidx - 1) % FRAME) == 0);
      end
      a_prev = a_cur;
      aidx++;
    end else begin
      in_data  = 8'($urandom_range(0, 255));
      in_valid = 1'b0;
    end
    @(posedge clk_1x);
    #1;
    check("out_valid", 16'(out_valid), 16'(valid && exp_lock));
    if (out_valid) begin
      if (exp_q.size() > 0) begin
        check("out_data", 16'(out_data), 16'(exp_q.pop_front()));
        check("out_sync", 16'(out_sync), 16'(sync_q.pop_front()));
      end else begin
        check("extra_output", 16'd1, 16'd0);
      end
    end else begin
      check("sync_idle", 16'(out_sync), 16'd0);
    end
  endtask

  task automatic send_to(input int last);
    while (aidx <= last) send(1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},  16'(out_valid),  16'd0);
    check({tag, "_sync"},   16'(out_sync),   16'd0);
    check({tag, "_data"},   16'(out_data),   16'd0);
    check({tag, "_locked"}, 16'(locked),     16'd0);
    check({tag, "_offset"}, 16'(bit_offset), 16'd0);
    check({tag, "_state"},  16'(fsm_state),  16'd0);
  endtask

  initial begin
    aidx = 0; a_prev = 8'd0; off = 3; exp_lock = 1'b0;
    repeat (3) @(posedge clk_1x);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk_1x);
    #1;

    // Acquire at offset 3: lock on the third marker.
    send_to(32);
    check("offset_latched", 16'(bit_offset), 16'd3);
    check("unlocked_2_markers", 16'(locked), 16'd0);
    send_to(33);
    check("locked_3rd_marker", 16'(locked), 16'd1);
    exp_lock = 1'b1;
    send_to(66);

    // Three misses then a good marker keep lock and clear the miss count.
    bad_marker[80] = 1; bad_marker[96] = 1; bad_marker[112] = 1;
    send_to(113);
    check("locked_after_3_miss", 16'(locked), 16'd1);
`ifdef ICE40_SERDES_ALIGN_STATS_EN
    check("err_cnt_3", err_cnt, 16'd3);
`endif
    send_to(129);
    bad_marker[144] = 1; bad_marker[160] = 1; bad_marker[176] = 1;
    send_to(177);
    check("miss_cleared", 16'(locked), 16'd1);
`ifdef ICE40_SERDES_ALIGN_STATS_EN
    check("err_cnt_6", err_cnt, 16'd6);
`endif
    send_to(193);

    // Four consecutive misses drop lock; the final miss word still goes out.
    bad_marker[208] = 1; bad_marker[224] = 1; bad_marker[240] = 1; bad_marker[256] = 1;
    send_to(256);
    check("locked_3rd_miss", 16'(locked), 16'd1);
    send_to(257);
    check("unlock_4th_miss", 16'(locked), 16'd0);
    check("state_hunt", 16'(fsm_state), 16'd0);
`ifdef ICE40_SERDES_ALIGN_STATS_EN
    check("err_cnt_10", err_cnt, 16'd10);
`endif
    exp_lock = 1'b0;
    send_to(258);
    check("offset_held_hunt", 16'(bit_offset), 16'd3);
    send_to(304);
    check("relock_pending", 16'(locked), 16'd0);
    send_to(305);
    check("relocked", 16'(locked), 16'd1);
    exp_lock = 1'b1;

    // Gapped input on a locked stream: every valid word out exactly once.
    repeat (120) send(1'($urandom_range(0, 1)));
    send_to(aidx + 3);
    check("locked_before_rst", 16'(locked), 16'd1);
    check("queue_drained_1", 16'(exp_q.size()), 16'd0);

    // Asynchronous reset mid-frame.
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk_1x);
    @(posedge clk_1x);
    #1;
    rst_n = 1'b1;

    // Reacquire at offset 5 with the second marker corrupted during verify.
    aidx = 0; a_prev = 8'd0; off = 5; exp_lock = 1'b0;
    bad_marker.delete();
    bad_marker[16] = 1;
    send_to(1);
    check("verify_entered", 16'(fsm_state), 16'd1);
    check("offset_5", 16'(bit_offset), 16'd5);
    send_to(17);
    check("verify_miss_hunt", 16'(fsm_state), 16'd0);
    send_to(64);
    check("verify_relock_pending", 16'(locked), 16'd0);
    send_to(65);
    check("verify_relocked", 16'(locked), 16'd1);
    exp_lock = 1'b1;
    send_to(81);
    check("queue_drained_2", 16'(exp_q.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
